// File: rtl/display_timing_pkg.sv
// Shared display timing definitions: phase encoding, default 1024x768@60
// timing constants and a small helper that maps a sync request onto a polarity.
package display_timing_pkg;

    // Phase of one axis (horizontal or vertical) within its line/frame period
    typedef logic [1:0] phase_t;

    localparam phase_t PH_ACTIVE = 2'd0;
    localparam phase_t PH_FRONT  = 2'd1;
    localparam phase_t PH_SYNC   = 2'd2;
    localparam phase_t PH_BACK   = 2'd3;

    // Default 1024x768@60 timing
    localparam int unsigned DEF_H_ACTIVE = 1024;
    localparam int unsigned DEF_H_FP     = 24;
    localparam int unsigned DEF_H_SYNC   = 136;
    localparam int unsigned DEF_H_BP     = 160;
    localparam int unsigned DEF_V_ACTIVE = 768;
    localparam int unsigned DEF_V_FP     = 3;
    localparam int unsigned DEF_V_SYNC   = 6;
    localparam int unsigned DEF_V_BP     = 29;
    localparam logic        DEF_SYNC_POL = 1'b0;

    // Drive the asserted polarity while in the sync phase, its inverse otherwise
    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/display_timing_axis.sv
// One timing axis: a period counter plus the phase FSM that tracks which region
// (active, front porch, sync, back porch) the counter currently sits in.
// The next-state phase is exported so the parent can register flags that line
// up with the counter on the same edge. All four region lengths must be nonzero.
module display_timing_axis
    import display_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP,
    parameter int unsigned WIDTH  = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             adv_i,
    output logic [WIDTH-1:0] count_o,
    output phase_t           state_d_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] LAST_ACTIVE = WIDTH'(ACTIVE - 1);
    localparam logic [WIDTH-1:0] LAST_FRONT  = WIDTH'(ACTIVE + FP - 1);
    localparam logic [WIDTH-1:0] LAST_SYNC   = WIDTH'(ACTIVE + FP + SYNC - 1);
    localparam logic [WIDTH-1:0] LAST_TOTAL  = WIDTH'(ACTIVE + FP + SYNC + BP - 1);

    logic [WIDTH-1:0] count_q, count_d;
    phase_t           state_q, state_d;
    logic             wrap;

    // Next count and phase: step on advance, leaving a region on its last value
    always_comb begin
        count_d = count_q;
        state_d = state_q;
        wrap    = 1'b0;
        if (adv_i) begin
            if (count_q == LAST_TOTAL) begin
                count_d = '0;
                state_d = PH_ACTIVE;
                wrap    = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
                if (count_q == LAST_ACTIVE) begin
                    state_d = PH_FRONT;
                end else if (count_q == LAST_FRONT) begin
                    state_d = PH_SYNC;
                end else if (count_q == LAST_SYNC) begin
                    state_d = PH_BACK;
                end
            end
        end
    end

    // Counter and phase registers, cleared to the start of the active region
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            state_q <= PH_ACTIVE;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    assign count_o   = count_q;
    assign state_d_o = state_d;
    assign wrap_o    = wrap;

endmodule

// File: rtl/display_timing.sv
// Raster timing generator: horizontal and vertical axes plus registered sync,
// blank and frame event flags. Every flag is computed from the axes' next
// state so it is registered on the same edge as the counters it describes.
module display_timing
    import display_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = DEF_SYNC_POL
) (
    input  logic        vclock,
    input  logic        reset,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        frame_start,
    output logic        vblank_start,
    output logic [7:0]  frame_count
);

    localparam logic [9:0] V_LAST_VISIBLE = 10'(V_ACTIVE - 1);

    phase_t     h_state_d, v_state_d;
    logic       h_wrap, v_wrap;
    logic [9:0] v_count;

    logic       hsync_q, vsync_q, blank_q;
    logic       frame_start_q, vblank_start_q;
    logic [7:0] frame_count_q;

    logic       frame_wrap;

    display_timing_axis #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .WIDTH  (11)
    ) u_h_axis (
        .clk_i     (vclock),
        .rst_i     (reset),
        .adv_i     (1'b1),
        .count_o   (hcount),
        .state_d_o (h_state_d),
        .wrap_o    (h_wrap)
    );

    display_timing_axis #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .WIDTH  (10)
    ) u_v_axis (
        .clk_i     (vclock),
        .rst_i     (reset),
        .adv_i     (h_wrap),
        .count_o   (v_count),
        .state_d_o (v_state_d),
        .wrap_o    (v_wrap)
    );

    assign frame_wrap = h_wrap & v_wrap;

    // Flags and frame counter registered from next-state phases so they stay aligned with the counters
    always_ff @(posedge vclock or posedge reset) begin
        if (reset) begin
            hsync_q        <= ~SYNC_POL;
            vsync_q        <= ~SYNC_POL;
            blank_q        <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_count_q  <= 8'd0;
        end else begin
            hsync_q        <= sync_level(h_state_d == PH_SYNC, SYNC_POL);
            vsync_q        <= sync_level(v_state_d == PH_SYNC, SYNC_POL);
            blank_q        <= (h_state_d != PH_ACTIVE) || (v_state_d != PH_ACTIVE);
            frame_start_q  <= frame_wrap;
            vblank_start_q <= h_wrap && (v_count == V_LAST_VISIBLE);
            frame_count_q  <= frame_count_q + 8'(frame_wrap);
        end
    end

    assign vcount       = v_count;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign blank        = blank_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_display_timing.sv
// Self-checking bench for display_timing using a reduced raster so that
// hundreds of frames fit in a short run. Expected outputs come from the pixel
// index since reset release, decomposed with division and modulo.
module tb_display_timing;

    localparam int unsigned HA = 10;
    localparam int unsigned HF = 2;
    localparam int unsigned HS = 3;
    localparam int unsigned HB = 5;
    localparam int unsigned VA = 5;
    localparam int unsigned VF = 1;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 2;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FT = HT * VT;

    logic        vclock = 1'b0;
    logic        reset  = 1'b1;

    logic [10:0] hcount0, hcount1;
    logic [9:0]  vcount0, vcount1;
    logic        hsync0, hsync1, vsync0, vsync1;
    logic        blank0, blank1;
    logic        frameStart0, frameStart1;
    logic        vblankStart0, vblankStart1;
    logic [7:0]  frameCount0, frameCount1;

    display_timing #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b0)
    ) dutLow (
        .vclock       (vclock),
        .reset        (reset),
        .hcount       (hcount0),
        .vcount       (vcount0),
        .hsync        (hsync0),
        .vsync        (vsync0),
        .blank        (blank0),
        .frame_start  (frameStart0),
        .vblank_start (vblankStart0),
        .frame_count  (frameCount0)
    );

    display_timing #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b1)
    ) dutHigh (
        .vclock       (vclock),
        .reset        (reset),
        .hcount       (hcount1),
        .vcount       (vcount1),
        .hsync        (hsync1),
        .vsync        (vsync1),
        .blank        (blank1),
        .frame_start  (frameStart1),
        .vblank_start (vblankStart1),
        .frame_count  (frameCount1)
    );

    // Free-running pixel clock
    always #5 vclock = ~vclock;

    typedef struct {
        int unsigned h;
        int unsigned v;
        logic        hsLow;
        logic        vsLow;
        logic        hsHigh;
        logic        vsHigh;
        logic        blank;
        logic        frameStart;
        logic        vblankStart;
        int unsigned frameCount;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monExp;
    int          assertCount = 0;
    int          failCount   = 0;
    longint unsigned pixelIndex = 0;

    // Reference: position and flags of the pixel shown t clocks after reset release
    function automatic exp_t modelAt(input longint unsigned t);
        exp_t e;
        longint unsigned line;
        logic hIn, vIn;
        line          = t / HT;
        e.h           = int'(t % HT);
        e.v           = int'(line % VT);
        hIn           = (e.h >= HA + HF) && (e.h < HA + HF + HS);
        vIn           = (e.v >= VA + VF) && (e.v < VA + VF + VS);
        e.hsLow       = !hIn;
        e.vsLow       = !vIn;
        e.hsHigh      = hIn;
        e.vsHigh      = vIn;
        e.blank       = (e.h >= HA) || (e.v >= VA);
        e.frameStart  = (t != 0) && (e.h == 0) && (e.v == 0);
        e.vblankStart = (e.h == 0) && (e.v == VA);
        e.frameCount  = int'((t / FT) % 256);
        return e;
    endfunction

    // Values every output must hold while reset is asserted
    function automatic exp_t resetRecord();
        exp_t e;
        e.h           = 0;
        e.v           = 0;
        e.hsLow       = 1'b1;
        e.vsLow       = 1'b1;
        e.hsHigh      = 1'b0;
        e.vsHigh      = 1'b0;
        e.blank       = 1'b0;
        e.frameStart  = 1'b0;
        e.vblankStart = 1'b0;
        e.frameCount  = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input longint unsigned actual,
                               input longint unsigned expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d (pixel index %0d)",
                     name, $time, actual, expected, pixelIndex);
        end
    endtask

    // Run n clocks holding reset at resetLevel (changed 1 time unit after the edge)
    task automatic applyStimulus(input int n, input logic resetLevel);
        for (int i = 0; i < n; i++) begin
            @(posedge vclock);
            if (!reset) pixelIndex++;
            #1;
            reset = resetLevel;
            if (reset) pixelIndex = 0;
            expQ.push_back(reset ? resetRecord() : modelAt(pixelIndex));
        end
    endtask

    // Monitor: each cycle the DUTs present a pixel, compare it to the oldest expectation
    always @(negedge vclock) begin
        if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkOutput("hcount",            hcount0,      monExp.h);
            checkOutput("vcount",            vcount0,      monExp.v);
            checkOutput("hsync",             hsync0,       monExp.hsLow);
            checkOutput("vsync",             vsync0,       monExp.vsLow);
            checkOutput("blank",             blank0,       monExp.blank);
            checkOutput("frame_start",       frameStart0,  monExp.frameStart);
            checkOutput("vblank_start",      vblankStart0, monExp.vblankStart);
            checkOutput("frame_count",       frameCount0,  monExp.frameCount);
            checkOutput("hcount_pol1",       hcount1,      monExp.h);
            checkOutput("vcount_pol1",       vcount1,      monExp.v);
            checkOutput("hsync_pol1",        hsync1,       monExp.hsHigh);
            checkOutput("vsync_pol1",        vsync1,       monExp.vsHigh);
            checkOutput("blank_pol1",        blank1,       monExp.blank);
            checkOutput("frame_start_pol1",  frameStart1,  monExp.frameStart);
            checkOutput("vblank_start_pol1", vblankStart1, monExp.vblankStart);
            checkOutput("frame_count_pol1",  frameCount1,  monExp.frameCount);
        end
    end

    // Stimulus: long run to wrap frame_count, a fixed mid-frame reset, then random resets
    initial begin
        applyStimulus(3, 1'b1);
        applyStimulus(257 * FT + 5, 1'b0);
        applyStimulus(2, 1'b1);
        applyStimulus(3 * HT + 7, 1'b0);
        applyStimulus(1, 1'b1);
        applyStimulus(FT + 10, 1'b0);
        for (int k = 0; k < 15; k++) begin
            applyStimulus(int'($urandom_range(1, 3 * FT)), 1'b0);
            applyStimulus(int'($urandom_range(1, 3)), 1'b1);
        end
        applyStimulus(2 * FT + 3, 1'b0);
        @(negedge vclock);
        #1;
        checkOutput("queue_drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/display_timing.md
DISPLAY_TIMING -- requirements
Module: display_timing

Interface
REQ-001 Parameter H_ACTIVE, 1024, visible pixels per line.
REQ-002 Parameter H_FP, 24, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, 136, hsync pulse width in clocks.
REQ-004 Parameter H_BP, 160, horizontal back porch in clocks; H_TOTAL = sum of the four = 1344.
REQ-005 Parameter V_ACTIVE, 768, visible lines per frame.
REQ-006 Parameter V_FP, 3, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 6, vsync pulse width in lines.
REQ-008 Parameter V_BP, 29, vertical back porch in lines; V_TOTAL = 806.
REQ-009 Parameter SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low).
REQ-010 vclock  input  1  pixel clock; one clock and one pixel per rising edge.
REQ-011 reset  input  1  asynchronous, active-high reset.
REQ-012 hcount  output  11  current pixel column, 0..H_TOTAL-1.
REQ-013 vcount  output  10  current line, 0..V_TOTAL-1.
REQ-014 hsync  output  1  horizontal sync at SYNC_POL while asserted.
REQ-015 vsync  output  1  vertical sync at SYNC_POL while asserted.
REQ-016 blank  output  1  high when (hcount,vcount) is outside the active area.
REQ-017 frame_start  output  1  one-clock pulse when the counters wrap to (0,0).
REQ-018 vblank_start  output  1  one-clock pulse when (hcount,vcount) = (0,V_ACTIVE).
REQ-019 frame_count  output  8  count of completed frames, wraps 255->0.

Function
REQ-020 All outputs are registered; hcount, vcount, and every derived flag describe the same pixel on the same cycle, with no skew between them.
REQ-021 hcount increments by 1 per clock; at H_TOTAL-1 it wraps to 0.
REQ-022 vcount increments by 1 only on the clock where hcount wraps; at V_TOTAL-1 with hcount wrap it wraps to 0.
REQ-023 A horizontal phase FSM with states ACTIVE (0..H_ACTIVE-1), FRONT, SYNC, and BACK advances at the phase boundaries; the current state equals the region containing hcount.
REQ-024 A vertical phase FSM with the same four states advances only on hcount wrap.
REQ-025 hsync = SYNC_POL iff hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [1048,1183]; otherwise it is ~SYNC_POL.
REQ-026 vsync = SYNC_POL iff vcount in [771,776], for the whole of each such line including non-active hcount.
REQ-027 blank = (hcount >= H_ACTIVE) or (vcount >= V_ACTIVE).
REQ-028 frame_start is 1 only on the cycle the outputs reach (0,0) via wrap; it is never asserted for the post-reset (0,0).
REQ-029 frame_count increments on the same clock edge that raises frame_start.
REQ-030 vblank_start is high for exactly one clock per frame.
REQ-031 Counter arithmetic uses the full port width with no overflow; comparisons are unsigned.

Reset
REQ-032 While reset is high: hcount=0, vcount=0, hsync=vsync=~SYNC_POL, blank=0, frame_start=0, vblank_start=0, frame_count=0, and both FSMs are in ACTIVE.
REQ-033 Reset asserted at any point mid-frame takes effect immediately and asynchronously, and the next frame restarts from (0,0).
REQ-034 On the first rising edge after reset deasserts, the outputs show (1,0).

Structure
REQ-035 Phase state enum and the default 1024x768@60 timing constants live in a shared display package.
REQ-036 One sub-module, timing_axis (phase FSM + counter, instantiated for H and V with an advance enable), is natural; no other hierarchy is required.

Verification
REQ-037 Reset release, run 1344 clocks -> hcount traces 1..1343 then 0, vcount steps 0->1 at the wrap.
REQ-038 Run one line -> hsync low for exactly 136 clocks from hcount 1048; blank rises at hcount 1024.
REQ-039 Run one full frame (1,083,264 clocks) -> frame_start pulses once at (0,0), frame_count = 1, vblank_start pulses once at (0,768), and vsync is low on lines 771..776 only.
REQ-040 Run 256 frames -> frame_count wraps to 0 with frame_start still pulsing.
REQ-041 Assert reset at (500,400) between edges -> outputs immediately return to reset values, and frame_start stays 0 at the next (0,0) reached from reset.
REQ-042 SYNC_POL=1 build -> hsync/vsync are high only within the REQ-025/REQ-026 windows and low at reset.
